seq_nibble_adder: RTL and testbench

- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus a carry-in, one 4-bit nibble per clock, through a single shared 4-bit full-adder slice with a registered carry.
- Generalises the team's combinational nibble adder to arbitrary multiples of 4 bits.
- Adds a start/busy/done handshake and an optional packed-BCD mode.
- Sits between operand registers and any consumer that can tolerate WIDTH/4-cycle latency in exchange for minimal adder area.

---
 rtl/seq_nibble_adder.sv | 152 +++++++++++++++
 tb/tb_seq_nibble_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit nibble per clock through a single shared slice, registered carry.
// Optional packed-BCD mode is compiled in with SEQ_NIBBLE_ADDER_BCD_EN (adds the bcd input port).
module seq_nibble_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
    input  logic             bcd,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_w_q, a_w_d;
    logic [WIDTH-1:0]   b_w_q, b_w_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

`ifdef SEQ_NIBBLE_ADDER_BCD_EN
    logic               bcd_q, bcd_d;
`else
    logic               bcd_q;
    assign bcd_q = 1'b0;
`endif

    logic [3:0]         nib_a, nib_b;
    logic [4:0]         t;
    logic [4:0]         t_adj;
    logic [3:0]         digit;
    logic               step_carry;

    // Shared nibble slice; decimal correction folds t > 9 back into 0..9 with a forced carry.
    always_comb begin
        nib_a      = a_w_q[4*idx_q +: 4];
        nib_b      = b_w_q[4*idx_q +: 4];
        t          = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        t_adj      = t + 5'd6;
        digit      = t[3:0];
        step_carry = t[4];
        if (bcd_q) begin
            if (t > 5'd9) begin
                digit      = t_adj[3:0];
                step_carry = 1'b1;
            end else begin
                step_carry = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_w_d   = a_w_q;
        b_w_d   = b_w_q;
        work_d  = work_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
        bcd_d   = bcd_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts exactly like IDLE so back-to-back starts skip the idle cycle.
                if (start) begin
                    a_w_d   = a;
                    b_w_d   = b;
                    work_d  = '0;
                    idx_d   = '0;
                    carry_d = cin;
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
                    bcd_d   = bcd;
`endif
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                work_d[4*idx_q +: 4] = digit;
                carry_d              = step_carry;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = step_carry;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_w_q   <= '0;
            b_w_q   <= '0;
            work_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
            bcd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_w_q   <= a_w_d;
            b_w_q   <= b_w_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
            bcd_q   <= bcd_d;
`endif
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_seq_nibble_adder.sv
// Bench for seq_nibble_adder: 16-bit instance driven through a result scoreboard, plus a 4-bit instance.
module tb_seq_nibble_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done;
    logic [15:0] sum;
    logic        cout;

    logic        s4_start;
    logic [3:0]  s4_a, s4_b;
    logic        s4_cin;
    logic        s4_busy, s4_done;
    logic [3:0]  s4_sum;
    logic        s4_cout;

`ifdef SEQ_NIBBLE_ADDER_BCD_EN
    logic        bcd_v;
    logic        s4_bcd;
`endif

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    seq_nibble_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
        .bcd(bcd_v),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    seq_nibble_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
        .bcd(s4_bcd),
`endif
        .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout)
    );

    // Result scoreboard: every done pulse pops one expected {cout,sum}.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL unexpected_done observed sum=%h cout=%b expected no done", sum, cout);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                assert ({cout, sum} === e) else begin
                    fails++;
                    $error("FAIL result observed cout=%b sum=%h expected cout=%b sum=%h",
                           cout, sum, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; returns number of busy cycles seen before it.
    task automatic wait_done(input string tag, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic tbcd, input logic [16:0] expv);
        int bc;
        a = ta; b = tb; cin = tc; start = 1'b1;
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
        bcd_v = tbcd;
`endif
        if (tbcd) begin end
        exp_q.push_back(expv);
        tick();
        start = 1'b0;
        wait_done(tag, bc);
        check({tag, "_busy_cycles"}, bc, 32'd4);
        check({tag, "_busy_low_in_done"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int bc;
        int d0;
        logic [15:0] ra, rb;
        logic rc;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_cin = 1'b0;
`ifdef SEQ_NIBBLE_ADDER_BCD_EN
        bcd_v = 1'b0; s4_bcd = 1'b0;
`endif
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst4_state", {28'd0, s4_busy, s4_done, s4_cout, 1'b0}, 32'd0);
        rst = 1'b0;
        tick();

        do_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 17'h0_0000);
        do_op("mixed", 16'h1234, 16'h5678, 1'b1, 1'b0, 17'h0_68AD);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000);
        check("held_sum", {16'd0, sum}, 32'h0000);
        check("held_cout", {31'd0, cout}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            do_op("rand", ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {16'd0, rc});
        end

        // Start pulse and operand churn during ADD must be ignored.
        d0 = done_cnt;
        a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
        exp_q.push_back(17'h0_0100);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
        tick();
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        wait_done("ignore", bc);
        repeat (4) tick();
        check("ignore_one_done", done_cnt - d0, 32'd1);

        // Back-to-back: start held through DONE re-enters ADD with no idle cycle.
        d0 = done_cnt;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        exp_q.push_back(17'h0_0003);
        tick();
        a = 16'h0010; b = 16'h0020; cin = 1'b1;
        exp_q.push_back(17'h0_0031);
        wait_done("b2b_first", bc);
        tick();
        start = 1'b0;
        check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
        check("b2b_no_idle_done", {31'd0, done}, 32'd0);
        wait_done("b2b_second", bc);
        check("b2b_second_busy", bc, 32'd4);
        repeat (2) tick();
        check("b2b_two_done", done_cnt - d0, 32'd2);

        // Reset mid-operation aborts with no done pulse and clears outputs.
        d0 = done_cnt;
        a = 16'h7777; b = 16'h1111; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        repeat (8) tick();
        check("abort_no_done", done_cnt - d0, 32'd0);
        do_op("after_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 17'h0_0007);

        // WIDTH=4: single ADD cycle.
        s4_a = 4'hF; s4_b = 4'hF; s4_cin = 1'b1; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        check("w4_busy", {31'd0, s4_busy}, 32'd1);
        tick();
        check("w4_done", {31'd0, s4_done}, 32'd1);
        check("w4_sum", {28'd0, s4_sum}, 32'hF);
        check("w4_cout", {31'd0, s4_cout}, 32'd1);
        tick();
        check("w4_done_pulse", {31'd0, s4_done}, 32'd0);

`ifdef SEQ_NIBBLE_ADDER_BCD_EN
        do_op("bcd_0999", 16'h0999, 16'h0001, 1'b0, 1'b1, 17'h0_1000);
        do_op("bcd_9999", 16'h9999, 16'h0001, 1'b0, 1'b1, 17'h1_0000);
        do_op("bcd_45_55", 16'h0045, 16'h0055, 1'b1, 1'b1, 17'h0_0101);
        do_op("bin_0999", 16'h0999, 16'h0001, 1'b0, 1'b0, 17'h0_099A);
        do_op("bin_9999", 16'h9999, 16'h0001, 1'b0, 1'b0, 17'h0_999A);
        do_op("bin_45_55", 16'h0045, 16'h0055, 1'b1, 1'b0, 17'h0_009B);
`endif

        repeat (2) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
